// File: rtl/fpu_pkg.sv
// Shared constants for the FPU issue controller: op-code ranges, latencies,
// FSM state encoding and the decoded-op record.
package fpu_pkg;

    localparam logic [5:0] OP_ADD_LAST   = 6'h03;
    localparam logic [5:0] OP_MUL_LAST   = 6'h05;
    localparam logic [5:0] OP_DIV_LAST   = 6'h09;
    localparam logic [5:0] OP_MISC_FIRST = 6'h10;
    localparam logic [5:0] OP_CMP_FIRST  = 6'h14;
    localparam logic [5:0] OP_CMP_LAST   = 6'h19;
    localparam logic [5:0] OP_MISC_LAST  = 6'h1F;
    localparam logic [5:0] OP_FMV_X      = 6'h20;
    localparam logic [5:0] OP_FMV_F      = 6'h21;

    localparam int LAT_W = 4;
    localparam int CNT_W = 3;

    localparam logic [LAT_W-1:0] LAT_ADD  = 4'd2;
    localparam logic [LAT_W-1:0] LAT_MUL  = 4'd3;
    localparam logic [LAT_W-1:0] LAT_DIV  = 4'd8;
    localparam logic [LAT_W-1:0] LAT_MISC = 4'd1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    typedef struct packed {
        logic [LAT_W-1:0] latency;
        logic             to_int;
        logic             nanbox;
        logic             illegal;
    } op_info_t;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational op-code classifier: latency, integer destination,
// NaN-boxing of single-precision results, and unsupported-op flag.
module fpu_op_decode
    import fpu_pkg::*;
#(
    parameter int OP_LEN = 6
) (
    input  logic [OP_LEN-1:0] op,
    output op_info_t          info
);

    logic is_cmp;

    assign is_cmp = (op >= OP_LEN'(OP_CMP_FIRST)) && (op <= OP_LEN'(OP_CMP_LAST));

    always_comb begin
        info.latency = LAT_MISC;
        info.to_int  = 1'b0;
        info.nanbox  = 1'b0;
        info.illegal = 1'b0;
        if (op <= OP_LEN'(OP_ADD_LAST)) begin
            info.latency = LAT_ADD;
        end else if (op <= OP_LEN'(OP_MUL_LAST)) begin
            info.latency = LAT_MUL;
        end else if (op <= OP_LEN'(OP_DIV_LAST)) begin
            info.latency = LAT_DIV;
        end else if ((op < OP_LEN'(OP_MISC_FIRST)) || (op > OP_LEN'(OP_FMV_F))) begin
            info.illegal = 1'b1;
        end
        // Odd codes below 0x20 are single precision; compares write the int file instead.
        if (!info.illegal) begin
            info.to_int = is_cmp || (op == OP_LEN'(OP_FMV_X));
            info.nanbox = op[0] && !is_cmp && (op <= OP_LEN'(OP_MISC_LAST));
        end
    end

endmodule

// File: rtl/fpu_ctrl.sv
// Single-issue FPU sequencer: latches one request, waits the op latency on a
// down-counter, formats the FPU result and holds it until writeback accepts.
module fpu_ctrl
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH = 64,
    parameter int OP_LEN    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_LEN-1:0]    req_op,
    input  logic [BUS_WIDTH-1:0] req_rs1,
    input  logic [BUS_WIDTH-1:0] req_rs2,
    input  logic [4:0]           req_rd,
    input  logic                 flush,
    output logic [BUS_WIDTH-1:0] fpu_in1,
    output logic [BUS_WIDTH-1:0] fpu_in2,
    output logic [OP_LEN-1:0]    fpu_op,
    input  logic [BUS_WIDTH-1:0] fpu_out,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [BUS_WIDTH-1:0] wb_data,
    output logic [4:0]           wb_rd,
    output logic                 wb_to_int,
    output logic                 wb_illegal,
    output logic                 busy
);

    localparam logic [BUS_WIDTH-1:0] LO_MASK = BUS_WIDTH'(64'h0000_0000_FFFF_FFFF);

    logic [1:0]           state;
    logic [OP_LEN-1:0]    op_q;
    logic [BUS_WIDTH-1:0] rs1_q;
    logic [BUS_WIDTH-1:0] rs2_q;
    logic [4:0]           rd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 to_int_q;
    logic                 nanbox_q;
    logic                 illegal_q;
    logic [BUS_WIDTH-1:0] wb_data_q;
    logic [4:0]           wb_rd_q;
    logic                 wb_to_int_q;
    logic                 wb_illegal_q;
    op_info_t             req_info;
    logic [BUS_WIDTH-1:0] result_fmt;

    fpu_op_decode #(.OP_LEN(OP_LEN)) u_decode (
        .op   (req_op),
        .info (req_info)
    );

    // Compares keep only the low word; fmv-to-int passes the full value through.
    always_comb begin
        result_fmt = fpu_out;
        if (illegal_q) begin
            result_fmt = '0;
        end else if (nanbox_q) begin
            result_fmt = (fpu_out & LO_MASK) | ~LO_MASK;
        end else if (to_int_q && (op_q != OP_LEN'(OP_FMV_X))) begin
            result_fmt = fpu_out & LO_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            to_int_q     <= 1'b0;
            nanbox_q     <= 1'b0;
            illegal_q    <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            wb_to_int_q  <= 1'b0;
            wb_illegal_q <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        rs1_q     <= req_rs1;
                        rs2_q     <= req_rs2;
                        rd_q      <= req_rd;
                        to_int_q  <= req_info.to_int;
                        nanbox_q  <= req_info.nanbox;
                        illegal_q <= req_info.illegal;
                        cnt_q     <= CNT_W'(req_info.latency - LAT_W'(1));
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        wb_data_q    <= result_fmt;
                        wb_rd_q      <= rd_q;
                        wb_to_int_q  <= to_int_q;
                        wb_illegal_q <= illegal_q;
                        state        <= ST_WB;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign wb_valid   = (state == ST_WB);
    assign fpu_in1    = rs1_q;
    assign fpu_in2    = rs2_q;
    assign fpu_op     = op_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;
    assign wb_to_int  = wb_to_int_q;
    assign wb_illegal = wb_illegal_q;

endmodule

// File: tb/tb_fpu_ctrl.sv
// Scoreboard bench for fpu_ctrl: directed corner cases then random ops,
// checked against a range-table reference model of latency and formatting.
module tb_fpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [63:0] req_rs1 = '0;
    logic [63:0] req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic [63:0] fpu_in1;
    logic [63:0] fpu_in2;
    logic [5:0]  fpu_op;
    logic [63:0] fpu_out;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_to_int;
    logic        wb_illegal;
    logic        busy;

    fpu_ctrl #(.BUS_WIDTH(64), .OP_LEN(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .flush      (flush),
        .fpu_in1    (fpu_in1),
        .fpu_in2    (fpu_in2),
        .fpu_op     (fpu_op),
        .fpu_out    (fpu_out),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_to_int  (wb_to_int),
        .wb_illegal (wb_illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [63:0] ONE_D   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO_D   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] THREE_D = 64'h4008_0000_0000_0000;
    localparam logic [63:0] ONE_S   = 64'hFFFF_FFFF_3F80_0000;
    localparam logic [63:0] TWO_S   = 64'hFFFF_FFFF_4000_0000;

    // Stand-in FPU: known answers for the directed cases, a scramble otherwise.
    function automatic logic [63:0] fpu_model(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op == 6'd0 && a == ONE_D && b == TWO_D) return THREE_D;
        if (op == 6'd1 && a == ONE_S && b == TWO_S) return 64'h0000_0000_4040_0000;
        return (a ^ {b[31:0], b[63:32]}) + {58'd0, op};
    endfunction

    always_comb fpu_out = fpu_model(fpu_op, fpu_in1, fpu_in2);

    function automatic int ref_lat(input int op);
        if (op <= 3) return 2;
        if (op <= 5) return 3;
        if (op <= 9) return 8;
        return 1;
    endfunction

    function automatic bit ref_illegal(input int op);
        return !(op <= 9 || (op >= 16 && op <= 33));
    endfunction

    function automatic bit ref_cmp(input int op);
        return op >= 20 && op <= 25;
    endfunction

    function automatic logic [63:0] ref_data(input int op, input logic [63:0] f);
        if (ref_illegal(op)) return 64'd0;
        if (ref_cmp(op)) return {32'd0, f[31:0]};
        if ((op % 2) == 1 && op <= 31) return {32'hFFFF_FFFF, f[31:0]};
        return f;
    endfunction

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        to_int;
        logic        illegal;
        int          lat;
        int          acc;
        int          bp;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({req_ready, wb_valid, wb_to_int, wb_illegal, busy, wb_rd, fpu_op}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0}));
        chk({tag, "_wb_data"}, wb_data, 64'd0);
        chk({tag, "_fpu_in1"}, fpu_in1, 64'd0);
        chk({tag, "_fpu_in2"}, fpu_in2, 64'd0);
    endtask

    // Caller sits just after a rising edge.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            $display("FAIL ready_timeout: req_ready got 0 expected 1 (cycle %0d)", cyc);
        end
    endtask

    // mode 0: normal, 1: flush in EXEC cycle 3, 2: reset in EXEC cycle 3
    task automatic issue(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input int bp, input int mode);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_rd    = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (mode == 0) begin
            e.a       = a;
            e.b       = b;
            e.op      = op;
            e.rd      = rd;
            e.data    = ref_data(int'(op), fpu_model(op, a, b));
            e.to_int  = !ref_illegal(int'(op)) && (ref_cmp(int'(op)) || op == 6'h20);
            e.illegal = ref_illegal(int'(op));
            e.lat     = ref_lat(int'(op));
            e.acc     = cyc;
            e.bp      = bp;
            sb.push_back(e);
        end else begin
            repeat (2) @(posedge clk);
            #1;
            if (mode == 1) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                chk("flush_exec_idle", 64'({busy, req_ready, wb_valid}), 64'(3'b010));
            end else begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                check_reset_outputs("reset_mid_exec");
                rst_n = 1'b1;
            end
        end
    endtask

    // Monitor: pops on each new writeback, checks hold stability and in-flight state.
    bit          prev_valid = 1'b0;
    bit          hs = 1'b0;
    int          hold = 0;
    logic [63:0] snap_data;
    logic [6:0]  snap_ctl;
    exp_t        m;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            hs         = 1'b0;
            hold       = 0;
            wb_ready   = 1'b1;
        end else begin
            if (hs) chk("wb_release", 64'({wb_valid, req_ready, busy}), 64'(3'b010));
            hs = 1'b0;
            if (wb_valid) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_wb: wb_valid got 1 expected 0 (cycle %0d)", cyc);
                        hold = 0;
                    end else begin
                        m = sb.pop_front();
                        chk("wb_data", wb_data, m.data);
                        chk("wb_rd", 64'(wb_rd), 64'(m.rd));
                        chk("wb_flags", 64'({wb_to_int, wb_illegal}), 64'({m.to_int, m.illegal}));
                        chk("wb_latency", 64'(cyc - m.acc), 64'(m.lat));
                        hold = m.bp;
                    end
                    snap_data = wb_data;
                    snap_ctl  = {wb_rd, wb_to_int, wb_illegal};
                end else begin
                    chk("wb_hold_data", wb_data, snap_data);
                    chk("wb_hold_ctl", 64'({wb_rd, wb_to_int, wb_illegal, req_ready, busy}),
                        64'({snap_ctl, 1'b0, 1'b1}));
                end
                wb_ready = (hold == 0);
                if (hold > 0) hold--;
                hs = wb_ready && !flush;
            end else begin
                if (sb.size() != 0) begin
                    chk("exec_busy", 64'({busy, req_ready}), 64'(2'b10));
                    chk("exec_fpu_in1", fpu_in1, sb[0].a);
                    chk("exec_fpu_in2", fpu_in2, sb[0].b);
                    chk("exec_fpu_op", 64'(fpu_op), 64'(sb[0].op));
                end
                wb_ready = 1'($urandom_range(0, 1));
            end
            prev_valid = wb_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        issue(6'h00, ONE_D, TWO_D, 5'd3, 0, 0);
        issue(6'h06, 64'h4022_0000_0000_0000, 64'h4008_0000_0000_0000, 5'd7, 0, 0);
        issue(6'h01, ONE_S, TWO_S, 5'd9, 0, 0);
        issue(6'h16, ONE_D, TWO_D, 5'd11, 0, 0);
        issue(6'h00, TWO_D, ONE_D, 5'd12, 5, 0);
        issue(6'h06, ONE_D, TWO_D, 5'd13, 0, 1);

        wait_ready(ok);
        req_valid = 1'b1;
        req_op    = 6'h04;
        flush     = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_idle_no_accept", 64'({busy, req_ready}), 64'(2'b01));

        issue(6'h3F, ONE_D, TWO_D, 5'd21, 1, 0);
        issue(6'h07, ONE_D, TWO_D, 5'd22, 0, 2);
        issue(6'h20, 64'hDEAD_BEEF_0123_4567, TWO_D, 5'd23, 2, 0);

        for (int i = 0; i < 60; i++) begin
            issue(6'($urandom_range(0, 63)), {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), $urandom_range(0, 3), 0);
        end

        for (int i = 0; i < 500 && (sb.size() != 0 || busy); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_queue", 64'(sb.size()), 64'd0);
        chk("drain_idle", 64'({busy, req_ready}), 64'(2'b01));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fpu_ctrl.md
FPU_CTRL -- requirements
Module: fpu_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, operand/result width.
REQ-002 SHALL have parameter OP_LEN, default 6, FPU operation code width.
REQ-003 SHALL have one clock and a synchronous, active-low reset (`clk`, `rst_n`); all state updates on the rising edge of `clk`.
REQ-004 SHALL have ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  1  issue request present.
- `req_ready`  out  1  controller can accept.
- `req_op`  in  OP_LEN  FPU operation code.
- `req_rs1`  in  BUS_WIDTH  operand 1.
- `req_rs2`  in  BUS_WIDTH  operand 2.
- `req_rd`  in  5  destination register index.
- `flush`  in  1  abort in-flight operation.
- `fpu_in1`  out  BUS_WIDTH  to FPU in1.
- `fpu_in2`  out  BUS_WIDTH  to FPU in2.
- `fpu_op`  out  OP_LEN  to FPU op select.
- `fpu_out`  in  BUS_WIDTH  combinational FPU result.
- `wb_valid`  out  1  result available.
- `wb_ready`  in  1  writeback consumer accepts.
- `wb_data`  out  BUS_WIDTH  result.
- `wb_rd`  out  5  destination index.
- `wb_to_int`  out  1  result targets integer register file.
- `wb_illegal`  out  1  op code unsupported.
- `busy`  out  1  state is not IDLE.

Function
REQ-005 SHALL implement an FSM with states IDLE, EXEC, WB.
REQ-006 SHALL drive `req_ready` = 1 only in IDLE; accept = `req_valid` & `req_ready`.
REQ-007 On accept, SHALL latch op, rs1, rs2 and rd, load the latency counter with L-1, and go to EXEC.
REQ-008 `fpu_in1`/`fpu_in2`/`fpu_op` SHALL be driven from the latched registers only; they hold stable throughout EXEC.
REQ-009 Latency L SHALL be:
- 2 for ops 000000–000011 (add/sub).
- 3 for ops 000100–000101 (mul).
- 8 for ops 000110–001001 (div/sqrt).
- 1 for ops 010000–011111 and 100000–100001.
- 1 for any other op, with `wb_illegal`=1.
REQ-010 In EXEC, if counter = 0, SHALL register the result and go to WB; otherwise it SHALL decrement.
REQ-011 `wb_valid` SHALL first be high in the cycle after the L-th rising edge following the accepting edge.
REQ-012 Result formatting (`wb_data`):
- Odd op codes in 000001–011111 with FP destination: bits [63:32] = 32'hFFFFFFFF (NaN-box) when BUS_WIDTH = 64, bits [31:0] from `fpu_out`.
- Compare ops 010100–011001: `wb_to_int`=1, upper bits zero.
- Op 100000 (fmv to int): `wb_to_int`=1.
- Illegal op: `wb_data` = 0.
- All other ops: `wb_data` = `fpu_out` unmodified, `wb_to_int`=0.
REQ-013 In WB, SHALL hold `wb_valid`, `wb_data`, `wb_rd`, `wb_to_int` and `wb_illegal` stable until `wb_ready`=1, then go to IDLE; there is no accept in the same cycle.
REQ-014 `flush`=1 in any state SHALL go to IDLE next cycle with no writeback; in IDLE, flush and `req_valid` together means flush wins and nothing is accepted.
REQ-015 `busy` SHALL be 1 in EXEC and WB.
REQ-016 Exactly one operation SHALL be in flight; no queuing.

Reset
REQ-017 When `rst_n`=0 at a clock edge, SHALL go to IDLE and clear all latched registers and the counter to 0.
REQ-018 Reset values SHALL be: `req_ready`=1, `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `wb_to_int`=0, `wb_illegal`=0, `busy`=0, `fpu_in1`/`fpu_in2`=0, `fpu_op`=0.
REQ-019 Reset mid-EXEC or mid-WB SHALL discard the operation; no `wb_valid` follows.

Structure
REQ-020 A shared package `fpu_pkg` SHALL hold the op-code constants, latency constants (LAT_ADD=2, LAT_MUL=3, LAT_DIV=8, LAT_MISC=1) and the FSM state encoding.
REQ-021 One combinational sub-module `fpu_op_decode` SHALL map op to {latency, to_int, nanbox, illegal}.
REQ-022 The FPU itself SHALL be instantiated outside this block.

Verification
REQ-023 Add.d: op 000000, rs1 = 0x3FF0000000000000, rs2 = 0x4000000000000000, FPU model returns 0x4008000000000000 -> `wb_valid` 2 cycles after accept, `wb_data` = 0x4008000000000000, `wb_to_int`=0.
REQ-024 Div.d: op 000110 -> `busy` high for 8 EXEC cycles; `req_ready`=0 throughout; `wb_valid` rises on cycle 8.
REQ-025 Add.s: op 000001, FPU returns 0x0000000040400000 -> `wb_data` = 0xFFFFFFFF40400000; flt.d op 010110 -> `wb_to_int`=1.
REQ-026 Backpressure: hold `wb_ready`=0 for 5 cycles in WB -> outputs stable; release -> IDLE next cycle, `req_ready`=1.
REQ-027 Flush at EXEC cycle 3 of div -> IDLE next cycle, no `wb_valid`; flush with `req_valid` in IDLE -> no accept.
REQ-028 Op 111111 -> `wb_illegal`=1, `wb_data`=0 after 1 cycle; `rst_n`=0 mid-EXEC -> all outputs at reset values next cycle.
